dc1_write_sched: RTL and testbench
==================================

// Module: dc1_write_sched
// PURPOSE
// Write-port scheduler for the L1 D-cache line RAM (dc1_xdata) and tag RAM (dc1_tdata).
// - Assembles line fills arriving in beats from the miss unit into one 512-bit line.
// - Issues each line as a single full-line write together with its tag write.
// - Interleaves committed byte-masked stores on the same shared write port.
// - Guarantees a fill write and a store write never occur in the same cycle, and that
//   no store lands on a line that is currently being filled.
// PARAMETERS
// NPHYS   55   physical address width; tag is bits [NPHYS-1:12]
// BEAT_W  128  fill beat width in bits; legal values 64, 128, 256; NBEATS = 512/BEAT_W (>= 2)
// PORTS
// clk          in   1        clock
// reset        in   1        asynchronous, active-high reset
// fill_valid   in   1        fill beat valid
// fill_ready   out  1        fill beat accepted when fill_valid && fill_ready
// fill_data    in   BEAT_W   beat data; beat k fills line bits [k*BEAT_W +: BEAT_W]
// fill_index   in   6        line set index; sampled on beat 0 only
// fill_tag     in   NPHYS-12 line tag; sampled on beat 0 only
// fill_abort   in   1        drop the partially collected line
// fill_done    out  1        1-cycle pulse, coincident with the line write
// st_valid     in   1        store commit valid
// st_ready     out  1        store accepted when st_valid && st_ready
// st_index     in   6        store line index
// st_word      in   3        64-bit word within the line
// st_data      in   64       store data
// st_mask      in   8        byte enables within the word
// wen          out  1        full-line write strobe to dc1_xdata
// waddr0       out  6        full-line write index
// din0         out  512      full-line write data
// wenb         out  64       byte write enables to dc1_xdata (used when wen=0)
// waddr1       out  6        store write index
// din1         out  512      store write data, {8{st_data}}
// tag_wen      out  1        tag write strobe to dc1_tdata; equal to wen
// tag_waddr    out  6        tag write index; equal to waddr0
// tag_din      out  NPHYS-12 tag write data
// busy         out  1        state != IDLE
// BEHAVIOUR
// Reset (async):
// - state=IDLE, beat_cnt=0, st_v_r=0.
// - wen, tag_wen, fill_done and wenb are all 0. Data and address registers are don't-care.
// Line FSM:
// - IDLE: fill_ready=1. A beat accepted here latches index and tag, stores beat 0,
//   sets beat_cnt=1, and moves to COLLECT.
// - COLLECT: fill_ready=1.
//   - Each accepted beat is written into slot beat_cnt, then beat_cnt increments.
//   - Accepting the beat with beat_cnt==NBEATS-1 moves to WRITE.
//   - fill_abort=1: return to IDLE with no write; a beat presented in the same cycle is
//     not accepted. Abort wins over the last beat.
// - WRITE: exactly 1 cycle, fill_ready=0.
//   - Outputs: wen=1, tag_wen=1, fill_done=1, din0 = assembled line,
//     waddr0 = tag_waddr = latched index.
//   - Next state is always IDLE. fill_abort is ignored.
// - Line latency: 1 cycle from acceptance of the last beat to wen.
// - Minimum period per line: NBEATS+1 cycles.
// Store path (one pipeline register):
// - A store accepted in cycle N produces, in cycle N+1:
//   - wenb[st_word*8 +: 8] = st_mask, all other wenb bits = 0;
//   - waddr1 = st_index, din1 = {8{st_data}}.
// - Throughput: 1 store per cycle when unblocked.
// - st_ready=0 when any of the following holds:
//   - state==WRITE;
//   - state==COLLECT && beat_cnt==NBEATS-1 (a WRITE may follow; no collision allowed);
//   - state==COLLECT && st_index==latched index (line under fill);
//   - state==IDLE && fill_valid && st_index==fill_index (fill being started).
// - Invariant: wen && |wenb is never true.
// - Stores to other indices proceed freely during COLLECT.
// Reset mid-operation: a partial line is discarded; a pending st_v_r is dropped
//   (no wenb is issued).
// TESTING
// 1. BEAT_W=128: 4 beats A0..A3 back-to-back to index 5, tag 0x1234 ->
//    wen=tag_wen=fill_done=1 in the cycle after A3; din0={A3,A2,A1,A0}; waddr0=5; busy drops.
// 2. Store idx 9, word 2, mask 0x0F, data 0x1122334455667788 ->
//    next cycle wenb=0x0000_0000_000F_0000, waddr1=9; store every cycle sustains 1/cycle.
// 3. Fill to idx 5 in COLLECT plus store to idx 5 -> st_ready=0 until the cycle after WRITE;
//    a store to idx 6 in the same window is accepted.
// 4. Store held valid across the last beat -> st_ready=0 on the last-beat cycle and in WRITE;
//    wen and wenb never both nonzero (assertion over random fill/store traffic).
// 5. fill_abort after 2 beats -> IDLE, no wen; a new 4-beat fill then writes correct data
//    with no stale beats.
// 6. reset asserted mid-COLLECT with a store in st_v_r -> all strobes 0 immediately;
//    no write after release.

Source files
------------

// File: rtl/dc1_write_sched.sv
// Write-port scheduler for the D-cache line RAM and tag RAM: fill assembly plus store interleave.
// Latency: full-line write 1 cycle after the last fill beat; store write 1 cycle after acceptance.
// Backpressure: fill_ready drops in WRITE or on abort; st_ready drops whenever a store could collide with a fill.
module dc1_write_sched #(
  parameter int NPHYS  = 55,
  parameter int BEAT_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [BEAT_W-1:0] fill_data,
  input  logic [5:0]        fill_index,
  input  logic [NPHYS-13:0] fill_tag,
  input  logic              fill_abort,
  output logic              fill_done,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [5:0]        st_index,
  input  logic [2:0]        st_word,
  input  logic [63:0]       st_data,
  input  logic [7:0]        st_mask,
  output logic              wen,
  output logic [5:0]        waddr0,
  output logic [511:0]      din0,
  output logic [63:0]       wenb,
  output logic [5:0]        waddr1,
  output logic [511:0]      din1,
  output logic              tag_wen,
  output logic [5:0]        tag_waddr,
  output logic [NPHYS-13:0] tag_din,
  output logic              busy
);

  localparam int NBEATS = 512 / BEAT_W;
  localparam int CW     = $clog2(NBEATS);
  localparam int TW     = NPHYS - 12;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  beat_cnt;
  logic [CW-1:0]  beat_slot;
  logic [511:0]   line;
  logic [5:0]     line_idx;
  logic [TW-1:0]  line_tag;
  logic           last_slot;
  logic           fill_acc;
  logic           st_acc;
  logic           st_v_r;
  logic [5:0]     st_index_r;
  logic [2:0]     st_word_r;
  logic [63:0]    st_data_r;
  logic [7:0]     st_mask_r;

  assign last_slot = (beat_cnt == CW'(NBEATS - 1));
  assign fill_acc  = fill_valid && fill_ready;
  // Beat 0 always lands in slot 0 regardless of the counter value in IDLE.
  assign beat_slot = (state == IDLE) ? '0 : beat_cnt;

  // Next-state and fill handshake; abort in COLLECT refuses the beat of the same cycle.
  always_comb begin
    state_nxt  = state;
    fill_ready = 1'b0;
    wen        = 1'b0;
    case (state)
      IDLE: begin
        fill_ready = 1'b1;
        if (fill_valid) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (fill_abort) begin
          state_nxt = IDLE;
        end else begin
          fill_ready = 1'b1;
          if (fill_valid && last_slot) state_nxt = WRITE;
        end
      end
      WRITE: begin
        wen       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (fill_acc)
        beat_cnt <= (state == IDLE) ? CW'(1) : beat_cnt + CW'(1);
      else if (state != COLLECT || fill_abort)
        beat_cnt <= '0;
    end
  end

  // Line assembly; index and tag are captured with beat 0 only.
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      line[beat_slot*BEAT_W +: BEAT_W] <= fill_data;
      if (state == IDLE) begin
        line_idx <= fill_index;
        line_tag <= fill_tag;
      end
    end
  end

  assign fill_done = wen;
  assign tag_wen   = wen;
  assign din0      = line;
  assign waddr0    = line_idx;
  assign tag_waddr = line_idx;
  assign tag_din   = line_tag;
  assign busy      = (state != IDLE);

  // Store gating: keep stores off the cycle a line write may occupy and off the line being filled.
  always_comb begin
    st_ready = 1'b1;
    if (state == WRITE)                                    st_ready = 1'b0;
    if (state == COLLECT && last_slot)                     st_ready = 1'b0;
    if (state == COLLECT && st_index == line_idx)          st_ready = 1'b0;
    if (state == IDLE && fill_valid && st_index == fill_index) st_ready = 1'b0;
  end

  assign st_acc = st_valid && st_ready;

  // Store pipeline valid bit; cleared on reset so a pending store never reaches the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st_v_r <= 1'b0;
    else       st_v_r <= st_acc;
  end

  // Store pipeline payload.
  always_ff @(posedge clk) begin
    if (st_acc) begin
      st_index_r <= st_index;
      st_word_r  <= st_word;
      st_data_r  <= st_data;
      st_mask_r  <= st_mask;
    end
  end

  // Byte enables: the word's mask placed at its byte lane group, zero elsewhere.
  always_comb begin
    wenb = '0;
    if (st_v_r) wenb[{st_word_r, 3'b000} +: 8] = st_mask_r;
  end

  assign waddr1 = st_index_r;
  assign din1   = {8{st_data_r}};

endmodule

// File: tb/tb_dc1_write_sched.sv
module tb_dc1_write_sched;

  localparam int NPHYS = 55;
  localparam int BW    = 128;
  localparam int NB    = 512 / BW;
  localparam int TW    = NPHYS - 12;

  logic          clk;
  logic          reset;
  logic          fill_valid;
  logic          fill_ready;
  logic [BW-1:0] fill_data;
  logic [5:0]    fill_index;
  logic [TW-1:0] fill_tag;
  logic          fill_abort;
  logic          fill_done;
  logic          st_valid;
  logic          st_ready;
  logic [5:0]    st_index;
  logic [2:0]    st_word;
  logic [63:0]   st_data;
  logic [7:0]    st_mask;
  logic          wen;
  logic [5:0]    waddr0;
  logic [511:0]  din0;
  logic [63:0]   wenb;
  logic [5:0]    waddr1;
  logic [511:0]  din1;
  logic          tag_wen;
  logic [5:0]    tag_waddr;
  logic [TW-1:0] tag_din;
  logic          busy;

  dc1_write_sched #(.NPHYS(NPHYS), .BEAT_W(BW)) dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_index(fill_index), .fill_tag(fill_tag), .fill_abort(fill_abort),
    .fill_done(fill_done),
    .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index),
    .st_word(st_word), .st_data(st_data), .st_mask(st_mask),
    .wen(wen), .waddr0(waddr0), .din0(din0), .wenb(wenb),
    .waddr1(waddr1), .din1(din1),
    .tag_wen(tag_wen), .tag_waddr(tag_waddr), .tag_din(tag_din),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line under fill is just the list of beats received so far.
  logic [BW-1:0] bq[$];
  logic [5:0]    m_idx;
  logic [TW-1:0] m_tag;
  bit            wr_now;
  bit            e_wen;
  bit            e_busy;
  logic [511:0]  e_din0;
  logic [5:0]    e_waddr0;
  logic [TW-1:0] e_tag;
  logic [63:0]   e_wenb;
  logic [5:0]    e_waddr1;
  logic [511:0]  e_din1;

  task automatic model_reset();
    bq.delete();
    wr_now = 0;
    e_wen  = 0;
    e_busy = 0;
    e_wenb = '0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies, advance the model.
  task automatic cyc(input logic fv, input logic [BW-1:0] fd, input logic [5:0] fi,
                     input logic [TW-1:0] ft, input logic fa, input logic sv,
                     input logic [5:0] si, input logic [2:0] sw, input logic [63:0] sd,
                     input logic [7:0] sm);
    bit e_fr, e_sr, facc, sacc, wr_next;
    @(negedge clk);
    chk("wen", wen, e_wen);
    chk("tag_wen", tag_wen, e_wen);
    chk("fill_done", fill_done, e_wen);
    chk("busy", busy, e_busy);
    chk("wenb", wenb, e_wenb);
    chk("excl", wen && (|wenb), 1'b0);
    if (e_wen) begin
      chk("din0", din0, e_din0);
      chk("waddr0", waddr0, e_waddr0);
      chk("tag_waddr", tag_waddr, e_waddr0);
      chk("tag_din", tag_din, e_tag);
    end
    if (e_wenb != 0) begin
      chk("waddr1", waddr1, e_waddr1);
      chk("din1", din1, e_din1);
    end
    fill_valid = fv; fill_data = fd; fill_index = fi; fill_tag = ft; fill_abort = fa;
    st_valid = sv; st_index = si; st_word = sw; st_data = sd; st_mask = sm;
    #1;
    e_fr = !wr_now && !(bq.size() > 0 && fa);
    e_sr = !wr_now
        && !(bq.size() == NB - 1)
        && !(bq.size() > 0 && si == m_idx)
        && !(bq.size() == 0 && fv && si == fi);
    chk("fill_ready", fill_ready, e_fr);
    chk("st_ready", st_ready, e_sr);
    facc = fv && e_fr;
    sacc = sv && e_sr;
    wr_next = 0;
    if (!wr_now) begin
      if (bq.size() > 0 && fa) begin
        bq.delete();
      end else if (facc) begin
        if (bq.size() == 0) begin
          m_idx = fi;
          m_tag = ft;
        end
        bq.push_back(fd);
        if (bq.size() == NB) begin
          for (int k = 0; k < NB; k++) e_din0[k*BW +: BW] = bq[k];
          e_waddr0 = m_idx;
          e_tag    = m_tag;
          wr_next  = 1;
          bq.delete();
        end
      end
    end
    e_wenb = '0;
    if (sacc) begin
      e_wenb   = 64'(sm) << (sw * 8);
      e_waddr1 = si;
      e_din1   = {8{sd}};
    end
    e_wen  = wr_next;
    e_busy = (bq.size() > 0) || wr_next;
    wr_now = wr_next;
  endtask

  task automatic idle();
    cyc(0, '0, '0, '0, 0, 0, '0, '0, '0, '0);
  endtask

  logic [BW-1:0] a [4];
  logic [BW-1:0] rd;
  logic [TW-1:0] rt;

  initial begin
    n_chk = 0;
    n_fail = 0;
    model_reset();
    reset = 1'b1;
    fill_valid = 0; fill_data = '0; fill_index = '0; fill_tag = '0; fill_abort = 0;
    st_valid = 0; st_index = '0; st_word = '0; st_data = '0; st_mask = '0;
    #2;
    chk("rst_wen", wen, 1'b0);
    chk("rst_tag_wen", tag_wen, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_wenb", wenb, 64'h0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Test 1: four back-to-back beats to index 5, tag 0x1234.
    for (int k = 0; k < 4; k++) a[k] = {4{32'hA000_0000 + 32'(k * 16 + 1)}};
    for (int k = 0; k < 4; k++) cyc(1, a[k], 6'd5, TW'('h1234), 0, 0, '0, '0, '0, '0);
    idle();
    chk("t1_wen", wen, 1'b1);
    chk("t1_din0", din0, {a[3], a[2], a[1], a[0]});
    chk("t1_waddr0", waddr0, 6'd5);
    chk("t1_tag_din", tag_din, TW'('h1234));
    idle();
    chk("t1_busy", busy, 1'b0);

    // Test 2: single store then a sustained store every cycle.
    cyc(0, '0, '0, '0, 0, 1, 6'd9, 3'd2, 64'h1122334455667788, 8'h0F);
    idle();
    chk("t2_wenb", wenb, 64'h0000_0000_000F_0000);
    chk("t2_waddr1", waddr1, 6'd9);
    chk("t2_din1", din1, {8{64'h1122334455667788}});
    for (int k = 0; k < 8; k++)
      cyc(0, '0, '0, '0, 0, 1, 6'(k + 20), 3'(k), {2{$urandom}}, 8'($urandom));
    idle();

    // Test 3: stores to the line under fill blocked, stores to a neighbour pass.
    cyc(1, a[0], 6'd5, TW'('h77), 0, 1, 6'd5, 3'd0, 64'h55, 8'hFF);
    chk("t3_blk_start", st_ready, 1'b0);
    cyc(1, a[1], 6'd0, '0, 0, 1, 6'd5, 3'd1, 64'h56, 8'hFF);
    chk("t3_blk_coll", st_ready, 1'b0);
    cyc(1, a[2], 6'd0, '0, 0, 1, 6'd6, 3'd1, 64'h66, 8'hF0);
    chk("t3_other", st_ready, 1'b1);
    cyc(1, a[3], 6'd0, '0, 0, 1, 6'd5, 3'd1, 64'h57, 8'hFF);
    cyc(0, '0, '0, '0, 0, 1, 6'd5, 3'd1, 64'h58, 8'hFF);
    chk("t3_blk_write", st_ready, 1'b0);
    cyc(0, '0, '0, '0, 0, 1, 6'd5, 3'd3, 64'h59, 8'h3C);
    chk("t3_after", st_ready, 1'b1);
    idle();

    // Test 4: store held valid across the last beat and the WRITE cycle.
    for (int k = 0; k < 4; k++) begin
      cyc(1, ~a[k], 6'd10, TW'('h99), 0, 1, 6'd11, 3'd4, 64'hABCD, 8'h81);
      if (k == 3) chk("t4_last", st_ready, 1'b0);
    end
    cyc(0, '0, '0, '0, 0, 1, 6'd11, 3'd4, 64'hABCD, 8'h81);
    chk("t4_write", st_ready, 1'b0);
    idle(); idle();

    // Test 5: abort after two beats, then a clean fill.
    cyc(1, a[3], 6'd12, TW'('h5), 0, 0, '0, '0, '0, '0);
    cyc(1, a[2], 6'd0, '0, 0, 0, '0, '0, '0, '0);
    cyc(1, a[1], 6'd0, '0, 1, 0, '0, '0, '0, '0);
    idle();
    chk("t5_abort_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1, {4{32'(k + 100)}}, 6'd13, TW'('h6), 0, 0, '0, '0, '0, '0);
    idle();
    chk("t5_din0", din0, {{4{32'd103}}, {4{32'd102}}, {4{32'd101}}, {4{32'd100}}});
    chk("t5_waddr0", waddr0, 6'd13);
    idle();

    // Test 6: reset in the middle of a fill with a store in flight.
    cyc(1, a[0], 6'd20, TW'('h3), 0, 1, 6'd7, 3'd5, 64'h1234, 8'hFF);
    cyc(1, a[1], 6'd0, '0, 0, 1, 6'd8, 3'd6, 64'h4321, 8'h0F);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_wenb", wenb, 64'h0);
    chk("t6_wen", wen, 1'b0);
    chk("t6_tag_wen", tag_wen, 1'b0);
    chk("t6_fill_done", fill_done, 1'b0);
    chk("t6_busy", busy, 1'b0);
    model_reset();
    fill_valid = 0; st_valid = 0; fill_abort = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rt = TW'({$urandom, $urandom});
      cyc(($urandom_range(0, 3) != 0), rd, 6'($urandom_range(0, 3)), rt,
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) != 0), 6'($urandom_range(0, 3)), 3'($urandom),
          {$urandom, $urandom}, 8'($urandom));
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
